// File: rtl/waveform_uart_packetizer.sv
// Captures one gated trigger window of ADC samples plus its pulse height, then
// streams it as a framed, checksummed byte packet over a valid/ready byte port.
module waveform_uart_packetizer #(
    parameter int         N_SAMPLES = 32,
    parameter int         SAMPLE_W  = 14,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                trig_in,
    input  logic [SAMPLE_W-1:0] pulse_height,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [7:0]          dropped_count
);

    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    state_t              state_q, state_d;
    logic                trig_q;
    logic [7:0]          count_q, count_d;
    logic [9:0]          idx_q, idx_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          drop_q, drop_d;
    logic [15:0]         ph_q;
    logic [SAMPLE_W-1:0] buf_q [N_SAMPLES];

    logic                rise;
    logic                wrEn;
    logic [IDX_W-1:0]    wrAddr;
    logic                phLatch;
    logic [9:0]          lastIdx;
    logic [9:0]          sOff;
    logic [15:0]         s16;
    logic [7:0]          curByte;

    assign rise    = trig_in & ~trig_q;
    assign lastIdx = 10'd4 + {1'b0, count_q, 1'b0};
    assign sOff    = idx_q - 10'd4;
    assign s16     = 16'(buf_q[sOff[IDX_W:1]]);

    // Byte under the cursor; idx_q only moves on a transfer, so this holds during stalls.
    always_comb begin
        curByte = 8'h00;
        if (idx_q == 10'd0) begin
            curByte = SYNC_BYTE;
        end else if (idx_q == 10'd1) begin
            curByte = count_q;
        end else if (idx_q == 10'd2) begin
            curByte = ph_q[15:8];
        end else if (idx_q == 10'd3) begin
            curByte = ph_q[7:0];
        end else if (idx_q == lastIdx) begin
            curByte = chk_q;
        end else begin
            curByte = sOff[0] ? s16[7:0] : s16[15:8];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        drop_d   = drop_q;
        wrEn     = 1'b0;
        wrAddr   = count_q[IDX_W-1:0];
        phLatch  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    wrEn    = 1'b1;
                    wrAddr  = '0;
                    count_d = 8'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (trig_in) begin
                    if (count_q < 8'(N_SAMPLES)) begin
                        wrEn    = 1'b1;
                        count_d = count_q + 8'd1;
                    end
                end else begin
                    phLatch = 1'b1;
                    idx_d   = '0;
                    chk_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = curByte;
                if (rise && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                if (tx_ready) begin
                    if (idx_q == lastIdx) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                    // Checksum covers every byte except the sync byte.
                    if (idx_q != 10'd0) begin
                        chk_d = chk_q + curByte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            count_q <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            drop_q  <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_in;
            count_q <= count_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            drop_q  <= drop_d;
            if (phLatch) begin
                ph_q <= 16'(pulse_height);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            buf_q[wrAddr] <= sample_in;
        end
    end

    assign busy          = (state_q != IDLE);
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_waveform_uart_packetizer.sv
// Self-checking bench for waveform_uart_packetizer: a byte scoreboard is filled
// from the window stimulus and drained as the DUT hands bytes over.
module tb_waveform_uart_packetizer;

    localparam int N = 32;
    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          trig_in = 1'b0;
    logic [SW-1:0] pulse_height = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic [7:0]    dropped_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] expQ[$];

    waveform_uart_packetizer #(.N_SAMPLES(N), .SAMPLE_W(SW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk),
        .reset(reset),
        .sample_in(sample_in),
        .trig_in(trig_in),
        .pulse_height(pulse_height),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    // Reference packet builder: pushes the expected byte stream for a window.
    task automatic pushPacket(input logic [15:0] s[$], input logic [15:0] ph);
        int n;
        logic [7:0] sum;
        logic [15:0] v;
        n = (s.size() < N) ? s.size() : N;
        expQ.push_back(8'hA5);
        expQ.push_back(8'(n));
        expQ.push_back(ph[15:8]);
        expQ.push_back(ph[7:0]);
        sum = 8'(n) + ph[15:8] + ph[7:0];
        for (int i = 0; i < n; i++) begin
            v = s[i] & 16'h3FFF;
            expQ.push_back(v[15:8]);
            expQ.push_back(v[7:0]);
            sum = sum + v[15:8] + v[7:0];
        end
        expQ.push_back(sum);
    endtask

    task automatic driveWindow(input logic [15:0] s[$], input logic [15:0] ph);
        logic [15:0] v;
        for (int i = 0; i < s.size(); i++) begin
            @(negedge clk);
            v = s[i];
            trig_in = 1'b1;
            sample_in = v[SW-1:0];
        end
        @(negedge clk);
        trig_in = 1'b0;
        sample_in = '0;
        v = ph;
        pulse_height = v[SW-1:0];
    endtask

    // Drains the scoreboard; readyMode 0 = ready held high, 1 = ready toggling.
    task automatic collectPacket(input int readyMode, input int raiseAt, input string name);
        int cyc = 0;
        int idx = 0;
        logic stall = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        while (expQ.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            if (cyc == raiseAt) trig_in = 1'b1;
            tx_ready = (readyMode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    failures++;
                    $display("[TB] FAIL %s_stable byte=%0d valid=%b data=%h required valid=1 data=%h", name, idx, tx_valid, tx_data, held);
                end
            end
            if (readyMode == 0) begin
                checks++;
                if (tx_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL %s_nobubble cycle=%0d valid=%b required 1", name, cyc, tx_valid);
                end
            end
            if (tx_valid === 1'b1) begin
                if (tx_ready) begin
                    exp = expQ.pop_front();
                    checks++;
                    if (tx_data !== exp) begin
                        failures++;
                        $display("[TB] FAIL %s_byte idx=%0d got=%h required=%h", name, idx, tx_data, exp);
                    end
                    idx++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    held = tx_data;
                end
            end else begin
                stall = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_timeout remaining=%0d required 0", name, expQ.size());
            expQ.delete();
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_end valid=%b busy=%b required 0 0", name, tx_valid, busy);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s[$], input logic [15:0] ph,
                                 input int readyMode, input string name);
        pushPacket(s, ph);
        driveWindow(s, ph);
        collectPacket(readyMode, -1, name);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || dropped_count !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset valid=%b data=%h busy=%b drop=%0d required 0 00 0 0", tx_valid, tx_data, busy, dropped_count);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_window;
        logic [15:0] s[$];
        for (int i = 0; i < 32; i++) s.push_back(16'h0100 + 16'(i));
        applyStimulus(s, 16'h0123, 0, "full");
    endtask

    task automatic test_backpressure;
        logic [15:0] s[$];
        for (int i = 0; i < 32; i++) s.push_back(16'h0100 + 16'(i));
        applyStimulus(s, 16'h0123, 1, "bp");
    endtask

    task automatic test_short_window;
        logic [15:0] s[$];
        for (int i = 0; i < 5; i++) s.push_back(16'h3FFF);
        applyStimulus(s, 16'h0000, 0, "short");
    endtask

    task automatic test_long_window;
        logic [15:0] s[$];
        for (int i = 0; i < 40; i++) s.push_back(16'((16'h2000 + 16'(i * 37)) & 16'h3FFF));
        applyStimulus(s, 16'h3ABC, 1, "long");
    endtask

    task automatic test_drop;
        logic [15:0] s[$];
        for (int i = 0; i < 5; i++) s.push_back(16'($urandom_range(0, 16'h3FFF)));
        pushPacket(s, 16'h0777);
        driveWindow(s, 16'h0777);
        collectPacket(0, 4, "drop");
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drop_nosecond valid=%b busy=%b required 0 0", tx_valid, busy);
            end
        end
        checks++;
        if (dropped_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL drop_count got=%0d required 1", dropped_count);
        end
        trig_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_saturate;
        logic [15:0] s[$];
        for (int i = 0; i < 3; i++) s.push_back(16'h0055 + 16'(i));
        pushPacket(s, 16'h0010);
        driveWindow(s, 16'h0010);
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            trig_in = 1'b1;
            @(negedge clk);
            trig_in = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (dropped_count !== 8'd255) begin
            failures++;
            $display("[TB] FAIL drop_saturate got=%0d required 255", dropped_count);
        end
        collectPacket(0, -1, "sat");
    endtask

    task automatic test_reset_mid_send;
        logic [15:0] s[$];
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) s.push_back(16'h1234 + 16'(i));
        pushPacket(s, 16'h0ABC);
        driveWindow(s, 16'h0ABC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            exp = expQ.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp) begin
                failures++;
                $display("[TB] FAIL midrst_byte idx=%0d valid=%b got=%h required=%h", i, tx_valid, tx_data, exp);
            end
        end
        expQ.delete();
        @(negedge clk);
        tx_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || dropped_count !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_state valid=%b drop=%0d busy=%b required 0 0 0", tx_valid, dropped_count, busy);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        s.delete();
        for (int i = 0; i < 6; i++) s.push_back(16'h0F00 + 16'(i * 3));
        applyStimulus(s, 16'h1FFF, 0, "postrst");
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_backpressure();
        test_short_window();
        test_long_window();
        test_drop();
        test_drop_saturate();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
